pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- id_rs_i, id_rt_i  in  5  source register numbers in ID.
- id_rs_used_i, id_rt_used_i  in  1  ID instruction reads rs / rt.
- ex_reg_write_i  in  2  writeback source select of the EX instruction.
- ex_reg_we_i  in  1  EX instruction writes a register.
- ex_wR_i  in  5  EX destination register.
- ex_branch_taken_i  in  1  EX resolved a taken branch or jump.
- mem_access_i  in  1  MEM stage holds a load or store.
- dmem_ack_i, imem_ack_i  in  1  memory done this cycle.
- dmem_req_o, imem_req_o  out  1  memory request, held until ack.
- pc_stop_o, if_id_stop_o, id_ex_stop_o, ex_mem_stop_o, mem_wb_stop_o  out  1  hold the PC / pipeline register.
- if_id_flush_o, id_ex_flush_o  out  1  load a bubble at the next edge.
- stall_cnt_o  out  16  saturating count of stalled cycles.
- bus_timeout_o  out  1  sticky watchdog flag.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum wait cycles before the watchdog fires.

Function
REQ-004 The state machine SHALL have three states: RUN, D_WAIT and I_WAIT.
REQ-005 dmem_req_o SHALL equal mem_access_i in RUN and SHALL be 1 in D_WAIT.
REQ-006 imem_req_o SHALL be 1 in every state except D_WAIT.
REQ-007 A dmem stall SHALL exist when dmem_req_o=1 and dmem_ack_i=0.
- During a dmem stall, all five stop outputs SHALL be 1 and both flush outputs SHALL be 0.
- A zero-wait ack (ack in the same cycle as req) SHALL cause no stall.
REQ-008 Transition RUN->D_WAIT SHALL occur on a dmem stall; D_WAIT->RUN SHALL occur on dmem_ack_i, and the pipeline SHALL advance at that same edge.
REQ-009 An imem stall SHALL exist when imem_req_o=1, imem_ack_i=0 and no dmem stall exists; the FSM SHALL move RUN->I_WAIT and return to RUN on imem_ack_i.
REQ-010 On an imem stall without a taken branch:
- pc_stop_o=1 and if_id_flush_o=1;
- later stages SHALL advance unless another rule below holds them.
REQ-011 A taken branch during an imem stall SHALL be deferred:
- all stops=1 until imem_ack_i;
- then REQ-012 applies in the ack cycle.
This prevents the fetch address changing mid-handshake.
REQ-012 A taken branch with no stall SHALL give if_id_flush_o=1, id_ex_flush_o=1 and pc_stop_o=0 (PC loads the target).
REQ-013 A load-use hazard SHALL be detected when all of the following hold: ex_reg_we_i=1, ex_reg_write_i=REG_SRC_MEM, ex_wR_i!=0, and a used ID source equals ex_wR_i.
- It SHALL give pc_stop_o=1, if_id_stop_o=1 and id_ex_flush_o=1 for exactly one cycle.
REQ-014 Priority SHALL be, highest first: dmem stall > deferred branch > taken branch > load-use > imem stall.
- A branch coincident with a load-use hazard SHALL flush; no stall is taken.
REQ-015 A stop and a flush on the same register SHALL never be asserted together; flush applies only when that register is not stopped.
REQ-016 All stop, flush and req outputs SHALL be combinational from state and inputs.
REQ-017 stall_cnt_o SHALL increment on every cycle with pc_stop_o=1 and saturate at 16'hFFFF.
REQ-018 The wait counter SHALL count consecutive cycles spent in D_WAIT or I_WAIT and clear on leaving them.
- When it reaches TIMEOUT, bus_timeout_o SHALL set and stay set until reset.
- The FSM SHALL keep waiting after the timeout.

Reset
REQ-019 Reset SHALL return the FSM to RUN, with stall_cnt_o=0, bus_timeout_o=0 and the wait counter at 0.
REQ-020 While rst_n=0, all stop, flush and dmem_req_o outputs SHALL be 0 and imem_req_o SHALL be 1.
REQ-021 Reset asserted mid-handshake SHALL abandon the pending request without waiting for ack.

Structure
REQ-022 The shared CPU package SHALL hold:
- the FSM state encoding;
- REG_SRC_MEM=2'h1 and the other writeback-source encodings;
- the default TIMEOUT.
REQ-023 The hazard and priority logic SHALL stay flat in pipeline_ctrl.
REQ-024 The saturating counter plus watchdog SHALL be one sub-module, stall_monitor.

Verification
REQ-025 Load-use: ex_reg_write=1, we=1, wR=5, id_rs=5, used=1 -> exactly one cycle with pc_stop=if_id_stop=id_ex_flush=1; stall_cnt +1.
REQ-026 Same load-use stimulus with wR=0, or with rs_used=0 -> no stall.
REQ-027 dmem, 3-cycle ack latency: mem_access=1 with ack on cycle 3 ->
- all stops=1 for cycles 0-2;
- dmem_req high throughout;
- state D_WAIT then RUN;
- stall_cnt=3.
REQ-028 Branch taken during an imem stall, imem ack after 2 cycles ->
- all stops=1 for 2 cycles;
- then both flushes=1 with pc_stop=0 in the ack cycle.
REQ-029 Branch and load-use in the same cycle -> flushes=1, pc_stop=0, no stall.
REQ-030 dmem_ack withheld 300 cycles ->
- bus_timeout_o=1 after cycle 255 and stays 1 after the ack;
- a mid-wait rst_n pulse clears it and the FSM is in RUN.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU definitions: controller state encoding, writeback-source
// encodings and the default bus-wait watchdog limit.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_D_WAIT = 2'd1,
    ST_I_WAIT = 2'd2
  } ctrl_state_e;

  // Writeback source select carried by the EX instruction.
  localparam logic [1:0] REG_SRC_ALU = 2'h0;
  localparam logic [1:0] REG_SRC_MEM = 2'h1;
  localparam logic [1:0] REG_SRC_PC  = 2'h2;
  localparam logic [1:0] REG_SRC_IMM = 2'h3;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned STALL_CNT_W     = 16;

  // True when an ID source operand is actually read and names register dst.
  function automatic logic src_match(input logic used, input logic [4:0] src,
                                     input logic [4:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/stall_monitor.sv
// Saturating stalled-cycle counter plus a sticky watchdog that fires once the
// controller has spent TIMEOUT consecutive cycles waiting on a memory ack.
module stall_monitor
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   waiting_i,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   bus_timeout_o
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                   timeout_q, timeout_d;

  // Next-state for both counters; the wait counter holds at the limit so the
  // flag stays meaningful while the controller keeps waiting.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    wait_cnt_d = '0;
    if (waiting_i) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (waiting_i && (wait_cnt_d == WAIT_LIMIT));
  end

  // Counter and flag registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign bus_timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: memory handshake FSM, load-use detection,
// branch flushing and the stop/flush priority network for a 5-stage CPU.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs_i,
  input  logic [4:0]             id_rt_i,
  input  logic                   id_rs_used_i,
  input  logic                   id_rt_used_i,
  input  logic [1:0]             ex_reg_write_i,
  input  logic                   ex_reg_we_i,
  input  logic [4:0]             ex_wR_i,
  input  logic                   ex_branch_taken_i,
  input  logic                   mem_access_i,
  input  logic                   dmem_ack_i,
  input  logic                   imem_ack_i,
  output logic                   dmem_req_o,
  output logic                   imem_req_o,
  output logic                   pc_stop_o,
  output logic                   if_id_stop_o,
  output logic                   id_ex_stop_o,
  output logic                   ex_mem_stop_o,
  output logic                   mem_wb_stop_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_flush_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   bus_timeout_o
);

  ctrl_state_e state_q, state_d;

  logic dmem_req, imem_req;
  logic dmem_stall, imem_stall, load_use;
  logic pc_stop, if_id_stop, id_ex_stop, ex_mem_stop, mem_wb_stop;
  logic if_id_flush, id_ex_flush;

  // Memory requests and hazard conditions; a data stall masks any fetch stall.
  always_comb begin
    dmem_req   = (state_q == ST_D_WAIT) ? 1'b1 : mem_access_i;
    imem_req   = (state_q != ST_D_WAIT);
    dmem_stall = dmem_req && !dmem_ack_i;
    imem_stall = imem_req && !imem_ack_i && !dmem_stall;
    load_use   = ex_reg_we_i && (ex_reg_write_i == REG_SRC_MEM) &&
                 (ex_wR_i != 5'd0) &&
                 (src_match(id_rs_used_i, id_rs_i, ex_wR_i) ||
                  src_match(id_rt_used_i, id_rt_i, ex_wR_i));
  end

  // Stop/flush priority; a branch seen mid-fetch freezes everything so the
  // fetch address cannot change until the instruction memory acks.
  always_comb begin
    pc_stop     = 1'b0;
    if_id_stop  = 1'b0;
    id_ex_stop  = 1'b0;
    ex_mem_stop = 1'b0;
    mem_wb_stop = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (dmem_stall || (ex_branch_taken_i && imem_stall)) begin
      pc_stop     = 1'b1;
      if_id_stop  = 1'b1;
      id_ex_stop  = 1'b1;
      ex_mem_stop = 1'b1;
      mem_wb_stop = 1'b1;
    end else if (ex_branch_taken_i) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stop     = 1'b1;
      if_id_stop  = 1'b1;
      id_ex_flush = 1'b1;
    end else if (imem_stall) begin
      pc_stop     = 1'b1;
      if_id_flush = 1'b1;
    end
  end

  // Handshake FSM next state: leave a wait state only on the matching ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (dmem_stall) begin
          state_d = ST_D_WAIT;
        end else if (imem_stall) begin
          state_d = ST_I_WAIT;
        end
      end
      ST_D_WAIT: if (dmem_ack_i) state_d = ST_RUN;
      ST_I_WAIT: if (imem_ack_i) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // State register; reset abandons any outstanding handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // While reset is held the pipeline is neither stopped nor flushed, no data
  // access is requested, and fetch stays requested.
  assign dmem_req_o    = rst_n & dmem_req;
  assign imem_req_o    = ~rst_n | imem_req;
  assign pc_stop_o     = rst_n & pc_stop;
  assign if_id_stop_o  = rst_n & if_id_stop;
  assign id_ex_stop_o  = rst_n & id_ex_stop;
  assign ex_mem_stop_o = rst_n & ex_mem_stop;
  assign mem_wb_stop_o = rst_n & mem_wb_stop;
  assign if_id_flush_o = rst_n & if_id_flush;
  assign id_ex_flush_o = rst_n & id_ex_flush;

  stall_monitor #(
    .TIMEOUT(TIMEOUT)
  ) u_stall_monitor (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (pc_stop_o),
    .waiting_i    (state_q != ST_RUN),
    .stall_cnt_o  (stall_cnt_o),
    .bus_timeout_o(bus_timeout_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized bench for pipeline_ctrl against a handshake-level
// reference model.
module tb_pipeline_ctrl;

  localparam int TB_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  id_rs_i, id_rt_i, ex_wR_i;
  logic        id_rs_used_i, id_rt_used_i, ex_reg_we_i, ex_branch_taken_i;
  logic [1:0]  ex_reg_write_i;
  logic        mem_access_i, dmem_ack_i, imem_ack_i;
  logic        dmem_req_o, imem_req_o;
  logic        pc_stop_o, if_id_stop_o, id_ex_stop_o, ex_mem_stop_o, mem_wb_stop_o;
  logic        if_id_flush_o, id_ex_flush_o;
  logic [15:0] stall_cnt_o;
  logic        bus_timeout_o;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_rs_i          (id_rs_i),
    .id_rt_i          (id_rt_i),
    .id_rs_used_i     (id_rs_used_i),
    .id_rt_used_i     (id_rt_used_i),
    .ex_reg_write_i   (ex_reg_write_i),
    .ex_reg_we_i      (ex_reg_we_i),
    .ex_wR_i          (ex_wR_i),
    .ex_branch_taken_i(ex_branch_taken_i),
    .mem_access_i     (mem_access_i),
    .dmem_ack_i       (dmem_ack_i),
    .imem_ack_i       (imem_ack_i),
    .dmem_req_o       (dmem_req_o),
    .imem_req_o       (imem_req_o),
    .pc_stop_o        (pc_stop_o),
    .if_id_stop_o     (if_id_stop_o),
    .id_ex_stop_o     (id_ex_stop_o),
    .ex_mem_stop_o    (ex_mem_stop_o),
    .mem_wb_stop_o    (mem_wb_stop_o),
    .if_id_flush_o    (if_id_flush_o),
    .id_ex_flush_o    (id_ex_flush_o),
    .stall_cnt_o      (stall_cnt_o),
    .bus_timeout_o    (bus_timeout_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which memory handshake is outstanding (0 none,
  // 1 data, 2 instruction), length of the current wait, counters.
  int mdl_pend      = 0;
  int mdl_wait_run  = 0;
  int mdl_stall_cnt = 0;
  bit mdl_timeout   = 1'b0;

  bit e_dreq, e_ireq, e_pc, e_ifid_s, e_idex_s, e_exmem_s, e_memwb_s;
  bit e_ifid_f, e_idex_f;

  // Last sampled outputs, for directed constant checks.
  logic [31:0] obs_stops, obs_flush, obs_req, obs_cnt, obs_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs from the controller rules for the current inputs.
  task automatic model_outputs(output int next_pend);
    bit dreq, ireq, dstall, istall, lu;
    dreq   = (mdl_pend == 1) || mem_access_i;
    ireq   = (mdl_pend != 1);
    dstall = dreq && !dmem_ack_i;
    istall = ireq && !imem_ack_i && !dstall;
    lu     = ex_reg_we_i && (ex_reg_write_i == 2'h1) && (ex_wR_i != 5'd0) &&
             ((id_rs_used_i && (id_rs_i == ex_wR_i)) ||
              (id_rt_used_i && (id_rt_i == ex_wR_i)));
    {e_pc, e_ifid_s, e_idex_s, e_exmem_s, e_memwb_s, e_ifid_f, e_idex_f} = '0;
    if (dstall || (ex_branch_taken_i && istall))
      {e_pc, e_ifid_s, e_idex_s, e_exmem_s, e_memwb_s} = '1;
    else if (ex_branch_taken_i) begin
      e_ifid_f = 1'b1;
      e_idex_f = 1'b1;
    end else if (lu) begin
      e_pc     = 1'b1;
      e_ifid_s = 1'b1;
      e_idex_f = 1'b1;
    end else if (istall) begin
      e_pc     = 1'b1;
      e_ifid_f = 1'b1;
    end
    e_dreq = dreq;
    e_ireq = ireq;
    if (mdl_pend == 2)      next_pend = imem_ack_i ? 0 : 2;
    else if (mdl_pend == 1) next_pend = dmem_ack_i ? 0 : 1;
    else if (dstall)        next_pend = 1;
    else if (istall)        next_pend = 2;
    else                    next_pend = 0;
    if (!rst_n) begin
      {e_pc, e_ifid_s, e_idex_s, e_exmem_s, e_memwb_s, e_ifid_f, e_idex_f} = '0;
      e_dreq    = 1'b0;
      e_ireq    = 1'b1;
      next_pend = 0;
    end
  endtask

  // One clock: sample at the falling edge, compare, then advance the model.
  task automatic cycle(input string tag);
    int next_pend;
    @(negedge clk);
    if (!rst_n) begin
      mdl_pend      = 0;
      mdl_wait_run  = 0;
      mdl_stall_cnt = 0;
      mdl_timeout   = 1'b0;
    end
    model_outputs(next_pend);
    obs_stops = 32'({pc_stop_o, if_id_stop_o, id_ex_stop_o, ex_mem_stop_o, mem_wb_stop_o});
    obs_flush = 32'({if_id_flush_o, id_ex_flush_o});
    obs_req   = 32'({dmem_req_o, imem_req_o});
    obs_cnt   = 32'(stall_cnt_o);
    obs_to    = 32'(bus_timeout_o);
    chk({tag, ".stops"}, obs_stops, 32'({e_pc, e_ifid_s, e_idex_s, e_exmem_s, e_memwb_s}));
    chk({tag, ".flush"}, obs_flush, 32'({e_ifid_f, e_idex_f}));
    chk({tag, ".req"}, obs_req, 32'({e_dreq, e_ireq}));
    chk({tag, ".stall_cnt"}, obs_cnt, 32'(mdl_stall_cnt));
    chk({tag, ".timeout"}, obs_to, 32'(mdl_timeout));
    @(posedge clk);
    if (rst_n) begin
      if (e_pc && (mdl_stall_cnt < 65535)) mdl_stall_cnt++;
      if (mdl_pend != 0) mdl_wait_run++;
      else mdl_wait_run = 0;
      if (mdl_wait_run >= TB_TIMEOUT) mdl_timeout = 1'b1;
      mdl_pend = next_pend;
    end
    #1;
  endtask

  task automatic idle();
    id_rs_i           = 5'd0;
    id_rt_i           = 5'd0;
    id_rs_used_i      = 1'b0;
    id_rt_used_i      = 1'b0;
    ex_reg_write_i    = 2'h0;
    ex_reg_we_i       = 1'b0;
    ex_wR_i           = 5'd0;
    ex_branch_taken_i = 1'b0;
    mem_access_i      = 1'b0;
    dmem_ack_i        = 1'b1;
    imem_ack_i        = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] wr, input logic rs_used);
    ex_reg_write_i = 2'h1;
    ex_reg_we_i    = 1'b1;
    ex_wR_i        = wr;
    id_rs_i        = 5'd5;
    id_rs_used_i   = rs_used;
  endtask

  initial begin
    logic [31:0] cnt_before;
    idle();
    // Reset with hostile inputs: outputs must be forced quiet.
    mem_access_i      = 1'b1;
    ex_branch_taken_i = 1'b1;
    dmem_ack_i        = 1'b0;
    imem_ack_i        = 1'b0;
    #2 rst_n = 1'b0;
    cycle("reset");
    cycle("reset");
    chk("reset.stops_zero", obs_stops, 32'h0);
    chk("reset.flush_zero", obs_flush, 32'h0);
    chk("reset.req_fetch_only", obs_req, 32'h1);
    chk("reset.cnt_zero", obs_cnt, 32'h0);
    chk("reset.timeout_zero", obs_to, 32'h0);
    rst_n = 1'b1;
    idle();
    cycle("idle");
    chk("idle.stops", obs_stops, 32'h0);

    // Load-use on rs: one cycle of stop PC/IF-ID with ID-EX bubble.
    set_load_use(5'd5, 1'b1);
    cycle("lu");
    chk("lu.stops_pc_ifid", obs_stops, 32'h18);
    chk("lu.flush_idex", obs_flush, 32'h1);
    idle();
    cycle("lu_after");
    chk("lu_after.stops", obs_stops, 32'h0);
    chk("lu_after.cnt", obs_cnt, 32'd1);

    // No hazard on r0 or when rs is not read.
    set_load_use(5'd0, 1'b1);
    cycle("lu_r0");
    chk("lu_r0.stops", obs_stops, 32'h0);
    set_load_use(5'd5, 1'b0);
    cycle("lu_unused");
    chk("lu_unused.stops", obs_stops, 32'h0);
    idle();
    cycle("lu_idle");
    chk("lu_idle.cnt", obs_cnt, 32'd1);

    // Data access acked on the fourth cycle.
    mem_access_i = 1'b1;
    dmem_ack_i   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("dmem_wait");
      chk("dmem_wait.all_stops", obs_stops, 32'h1F);
      chk("dmem_wait.dreq", obs_req[1], 32'h1);
    end
    chk("dmem_wait.in_dwait", obs_req, 32'h2);
    dmem_ack_i = 1'b1;
    cycle("dmem_ack");
    chk("dmem_ack.stops", obs_stops, 32'h0);
    chk("dmem_ack.req", obs_req, 32'h2);
    idle();
    cycle("dmem_done");
    chk("dmem_done.run", obs_req, 32'h1);
    chk("dmem_done.cnt", obs_cnt, 32'd4);

    // Branch during a fetch stall is held until the fetch acks.
    ex_branch_taken_i = 1'b1;
    imem_ack_i        = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle("br_defer");
      chk("br_defer.all_stops", obs_stops, 32'h1F);
      chk("br_defer.no_flush", obs_flush, 32'h0);
    end
    imem_ack_i = 1'b1;
    cycle("br_ack");
    chk("br_ack.stops", obs_stops, 32'h0);
    chk("br_ack.flush", obs_flush, 32'h3);
    idle();
    cycle("br_done");
    chk("br_done.cnt", obs_cnt, 32'd6);

    // Branch and load-use together: flush wins, no stall.
    set_load_use(5'd5, 1'b1);
    ex_branch_taken_i = 1'b1;
    cycle("br_lu");
    chk("br_lu.stops", obs_stops, 32'h0);
    chk("br_lu.flush", obs_flush, 32'h3);
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      id_rs_i           = 5'($urandom_range(0, 3));
      id_rt_i           = 5'($urandom_range(0, 3));
      id_rs_used_i      = 1'($urandom_range(0, 1));
      id_rt_used_i      = 1'($urandom_range(0, 1));
      ex_reg_write_i    = 2'($urandom_range(0, 3));
      ex_reg_we_i       = 1'($urandom_range(0, 1));
      ex_wR_i           = 5'($urandom_range(0, 3));
      ex_branch_taken_i = ($urandom_range(0, 3) == 0);
      mem_access_i      = ($urandom_range(0, 2) == 0);
      dmem_ack_i        = 1'($urandom_range(0, 1));
      imem_ack_i        = ($urandom_range(0, 2) != 0);
      cycle("rand");
    end
    idle();
    cycle("settle");
    cycle("settle");

    // Watchdog: data ack withheld for 300 cycles.
    cnt_before   = obs_cnt;
    mem_access_i = 1'b1;
    dmem_ack_i   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cycle("tmo");
      if (i == 255) chk("tmo.not_yet", obs_to, 32'h0);
      if (i == 256) chk("tmo.fired", obs_to, 32'h1);
    end
    chk("tmo.cnt", obs_cnt, cnt_before + 32'd299);
    chk("tmo.still_waiting", obs_stops, 32'h1F);
    dmem_ack_i = 1'b1;
    cycle("tmo_ack");
    chk("tmo_ack.sticky", obs_to, 32'h1);
    idle();
    cycle("tmo_idle");
    cycle("tmo_idle");
    chk("tmo_idle.sticky", obs_to, 32'h1);

    // Reset in the middle of a data wait.
    mem_access_i = 1'b1;
    dmem_ack_i   = 1'b0;
    for (int i = 0; i < 5; i++) cycle("rst_wait");
    rst_n = 1'b0;
    cycle("rst_mid");
    chk("rst_mid.timeout", obs_to, 32'h0);
    chk("rst_mid.req", obs_req, 32'h1);
    chk("rst_mid.cnt", obs_cnt, 32'h0);
    rst_n        = 1'b1;
    mem_access_i = 1'b0;
    cycle("rst_after");
    chk("rst_after.run", obs_req, 32'h1);
    chk("rst_after.stops", obs_stops, 32'h0);
    chk("rst_after.timeout", obs_to, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
